// File: rtl/lb_window_gen.sv
// Builds a 2-row x WIN_W-column sliding stencil from the live pixel stream and the line-buffer delayed row.
// Latency 1 from an accepted pixel to win_valid/line_end; clk_en=0 freezes everything except config writes.
// No backpressure on the input streams; err checker built only with LB_WIN_ERR_CHECK_EN defined.
module lb_window_gen #(
  parameter int DW    = 16,
  parameter int WIN_W = 3
) (
  input  logic                    clk_in,
  input  logic                    reset,
  input  logic                    clk_en,
  input  logic                    config_en,
  input  logic [31:0]             config_addr,
  input  logic [31:0]             config_data,
  output logic [31:0]             read_data,
  input  logic                    flush,
  input  logic [DW-1:0]           cur_in,
  input  logic                    cur_valid,
  input  logic [DW-1:0]           prev_in,
  input  logic                    prev_valid,
  output logic [2*WIN_W*DW-1:0]   win_out,
  output logic                    win_valid,
  output logic                    line_end,
  output logic                    err
);

  localparam int          ROW_BITS  = WIN_W * DW;
  localparam logic [15:0] FIRST_COL = 16'(WIN_W - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PRIME  = 2'd1,
    STREAM = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [15:0]         w_q, w_d;
  logic                enable_q, enable_d;
  logic [ROW_BITS-1:0] row0_q, row0_d;
  logic [ROW_BITS-1:0] row1_q, row1_d;
  logic [15:0]         col_q, col_d;
  logic [15:0]         row_cnt_q, row_cnt_d;
  logic                win_valid_q, win_valid_d;
  logic                line_end_q, line_end_d;

  logic cfg_wr;
  logic adv;
  logic last_col;

  assign cfg_wr   = config_en && (config_addr[7:0] == 8'h00);
  // A pixel arriving together with flush is discarded.
  assign adv      = clk_en && enable_q && cur_valid && !flush && (state_q != IDLE);
  // W=0 makes W-1 = 16'hFFFF, so the column counter wraps naturally at 65536.
  assign last_col = (col_q == (w_q - 16'd1));

  always_comb begin
    state_d     = state_q;
    w_d         = w_q;
    enable_d    = enable_q;
    row0_d      = row0_q;
    row1_d      = row1_q;
    col_d       = col_q;
    row_cnt_d   = row_cnt_q;
    win_valid_d = win_valid_q;
    line_end_d  = line_end_q;

    if (clk_en) begin
      win_valid_d = 1'b0;
      line_end_d  = 1'b0;
      if (flush) begin
        row0_d    = '0;
        row1_d    = '0;
        col_d     = '0;
        row_cnt_d = '0;
        state_d   = enable_q ? PRIME : IDLE;
      end else begin
        case (state_q)
          IDLE:    if (enable_q) state_d = PRIME;
          PRIME:   if (adv && prev_valid) state_d = STREAM;
          STREAM:  state_d = STREAM;
          default: state_d = IDLE;
        endcase

        if (adv) begin
          // Newest column enters at the top; prev row shifts even when prev_valid is low.
          row0_d      = {prev_in, row0_q[ROW_BITS-1:DW]};
          row1_d      = {cur_in,  row1_q[ROW_BITS-1:DW]};
          // Only a full window of same-row columns with a valid upper row qualifies.
          win_valid_d = prev_valid && (col_q >= FIRST_COL);
          line_end_d  = last_col;
          if (last_col) begin
            col_d = '0;
            if (row_cnt_q != 16'hFFFF) row_cnt_d = row_cnt_q + 16'd1;
          end else begin
            col_d = col_q + 16'd1;
          end
        end
      end
    end

    // Config writes bypass clk_en and take precedence over the column advance.
    if (cfg_wr) begin
      w_d      = config_data[15:0];
      enable_d = config_data[16];
      col_d    = '0;
      if (!config_data[16]) state_d = IDLE;
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q     <= IDLE;
      w_q         <= '0;
      enable_q    <= 1'b0;
      row0_q      <= '0;
      row1_q      <= '0;
      col_q       <= '0;
      row_cnt_q   <= '0;
      win_valid_q <= 1'b0;
      line_end_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      w_q         <= w_d;
      enable_q    <= enable_d;
      row0_q      <= row0_d;
      row1_q      <= row1_d;
      col_q       <= col_d;
      row_cnt_q   <= row_cnt_d;
      win_valid_q <= win_valid_d;
      line_end_q  <= line_end_d;
    end
  end

`ifdef LB_WIN_ERR_CHECK_EN
  logic err_q, err_d;

  // Upper row ahead of the live row, or upper row dropping out mid-stream.
  always_comb begin
    err_d = err_q;
    if (clk_en) begin
      if (flush) begin
        err_d = 1'b0;
      end else if ((enable_q && prev_valid && !cur_valid) ||
                   (adv && (state_q == STREAM) && !prev_valid)) begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign win_out   = {row1_q, row0_q};
  assign win_valid = win_valid_q;
  assign line_end  = line_end_q;
  assign read_data = {err, 14'b0, enable_q, w_q};

  logic unused_cfg_bits;
  assign unused_cfg_bits = ^{config_addr[31:8], config_data[31:17]};

endmodule

// File: tb/tb_lb_window_gen.sv
// Directed bench for lb_window_gen with a spec-level model and a window scoreboard.
module tb_lb_window_gen;

  localparam int DW = 16;
  localparam int WW = 3;
  localparam int WB = 2 * WW * DW;

  logic           clk_in = 1'b0;
  logic           reset;
  logic           clk_en;
  logic           config_en;
  logic [31:0]    config_addr;
  logic [31:0]    config_data;
  logic [31:0]    read_data;
  logic           flush;
  logic [DW-1:0]  cur_in;
  logic           cur_valid;
  logic [DW-1:0]  prev_in;
  logic           prev_valid;
  logic [WB-1:0]  win_out;
  logic           win_valid;
  logic           line_end;
  logic           err;

  int n_chk   = 0;
  int n_fail  = 0;
  int n_valid = 0;

  logic [WB-1:0] exp_q[$];

  logic [DW-1:0] h_cur[WW];
  logic [DW-1:0] h_prev[WW];
  logic [15:0]   m_w;
  logic [15:0]   m_col;
  logic          m_en, m_act, m_stream, m_err, m_wv, m_le;

  always #5 clk_in = ~clk_in;

  lb_window_gen #(.DW(DW), .WIN_W(WW)) dut (
    .clk_in      (clk_in),
    .reset       (reset),
    .clk_en      (clk_en),
    .config_en   (config_en),
    .config_addr (config_addr),
    .config_data (config_data),
    .read_data   (read_data),
    .flush       (flush),
    .cur_in      (cur_in),
    .cur_valid   (cur_valid),
    .prev_in     (prev_in),
    .prev_valid  (prev_valid),
    .win_out     (win_out),
    .win_valid   (win_valid),
    .line_end    (line_end),
    .err         (err)
  );

  function automatic logic [WB-1:0] model_win();
    logic [WB-1:0] w;
    w = '0;
    for (int c = 0; c < WW; c++) begin
      w[c*DW +: DW]      = h_prev[c];
      w[(WW+c)*DW +: DW] = h_cur[c];
    end
    return w;
  endfunction

  task automatic clear_hist();
    for (int c = 0; c < WW; c++) begin
      h_cur[c]  = '0;
      h_prev[c] = '0;
    end
  endtask

  task automatic chk(input string tag, input logic [WB-1:0] obs, input logic [WB-1:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Scoreboard: every window the DUT flags valid on an enabled edge must match the next expected one.
  always begin
    logic ce_s, rst_s;
    logic [WB-1:0] e;
    @(posedge clk_in);
    ce_s  = clk_en;
    rst_s = reset;
    #1;
    if (ce_s && !rst_s && win_valid) begin
      n_valid++;
      n_chk++;
      assert (exp_q.size() > 0) else begin
        n_fail++;
        $error("FAIL scoreboard_empty: observed win_valid 1 expected 0");
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("sb_window", win_out, e);
      end
    end
  end

  task automatic check_outputs();
    chk("win_valid", WB'(win_valid), WB'(m_wv));
    chk("line_end",  WB'(line_end),  WB'(m_le));
    chk("win_out",   win_out,        model_win());
    chk("read_data", WB'(read_data), WB'({m_err, 14'b0, m_en, m_w}));
  endtask

  task automatic cyc(input logic ce, input logic fl, input logic cv, input logic [DW-1:0] cd,
                     input logic pv, input logic [DW-1:0] pd);
    logic acc;
    @(negedge clk_in);
    clk_en = ce; flush = fl; config_en = 1'b0;
    cur_valid = cv; cur_in = cd; prev_valid = pv; prev_in = pd;
    if (ce) begin
      m_wv = 1'b0;
      m_le = 1'b0;
      if (fl) begin
        clear_hist();
        m_col = '0; m_err = 1'b0; m_stream = 1'b0; m_act = m_en;
      end else begin
        acc = m_en && m_act && cv;
`ifdef LB_WIN_ERR_CHECK_EN
        if (m_en && pv && !cv) m_err = 1'b1;
        if (acc && m_stream && !pv) m_err = 1'b1;
`endif
        if (acc) begin
          for (int c = 0; c < WW-1; c++) begin
            h_cur[c]  = h_cur[c+1];
            h_prev[c] = h_prev[c+1];
          end
          h_cur[WW-1]  = cd;
          h_prev[WW-1] = pd;
          m_wv  = pv && (m_col >= 16'(WW-1));
          m_le  = (m_col == m_w - 16'd1);
          m_col = m_le ? 16'd0 : m_col + 16'd1;
          if (pv) m_stream = 1'b1;
          if (m_wv) exp_q.push_back(model_win());
        end
        if (m_en) m_act = 1'b1;
      end
    end
    @(posedge clk_in);
    #1;
    check_outputs();
  endtask

  task automatic cfg(input logic [31:0] addr, input logic [15:0] w, input logic en);
    @(negedge clk_in);
    clk_en = 1'b1; flush = 1'b0; cur_valid = 1'b0; prev_valid = 1'b0;
    config_en = 1'b1; config_addr = addr; config_data = {15'd0, en, w};
    m_wv = 1'b0; m_le = 1'b0;
    if (m_en) m_act = 1'b1;
    if (addr[7:0] == 8'h00) begin
      m_w = w; m_en = en; m_col = '0;
      if (!en) begin m_act = 1'b0; m_stream = 1'b0; end
    end
    @(posedge clk_in);
    #1;
    config_en = 1'b0;
    check_outputs();
  endtask

  task automatic px(input int p, input logic pv, input int pd);
    cyc(1'b1, 1'b0, 1'b1, DW'(p), pv, DW'(pd));
  endtask

  task automatic check_row_valids(input string tag, input int expv);
    chk(tag, WB'(n_valid), WB'(expv));
    chk({tag, "_drained"}, WB'(exp_q.size()), WB'(0));
    n_valid = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [WB-1:0] first_win;
    reset = 1'b1; clk_en = 1'b1; config_en = 1'b0; config_addr = '0; config_data = '0;
    flush = 1'b0; cur_in = '0; cur_valid = 1'b0; prev_in = '0; prev_valid = 1'b0;
    clear_hist();
    m_w = '0; m_col = '0; m_en = 1'b0; m_act = 1'b0; m_stream = 1'b0; m_err = 1'b0;
    m_wv = 1'b0; m_le = 1'b0;

    // Reset held for three cycles: everything clears.
    repeat (3) @(posedge clk_in);
    #1;
    check_outputs();
    @(negedge clk_in);
    reset = 1'b0;

    // Configure W=10 enabled; a write to another address is ignored.
    cfg(32'h0, 16'd10, 1'b1);
    cfg(32'h4, 16'd5, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, '0, 1'b0, '0);

    // Continuous stream, upper row valid from pixel 11.
    first_win = {16'd13, 16'd12, 16'd11, 16'd3, 16'd2, 16'd1};
    n_valid = 0;
    for (int p = 1; p <= 30; p++) begin
      px(p, p >= 11, (p >= 11) ? p - 10 : 0);
      if (p == 13) chk("first_window", win_out, first_win);
    end
    check_row_valids("valids_continuous", 16);

    // Same stream with random idle gaps.
    cyc(1'b1, 1'b1, 1'b0, '0, 1'b0, '0);
    n_valid = 0;
    for (int p = 1; p <= 30; p++) begin
      while ($urandom_range(0, 1) == 1) cyc(1'b1, 1'b0, 1'b0, '0, 1'b0, '0);
      px(p, p >= 11, (p >= 11) ? p - 10 : 0);
    end
    check_row_valids("valids_gapped", 16);

    // Clock-enable stall mid-row with a pixel presented.
    cyc(1'b1, 1'b1, 1'b0, '0, 1'b0, '0);
    n_valid = 0;
    for (int p = 1; p <= 15; p++) px(p, p >= 11, (p >= 11) ? p - 10 : 0);
    repeat (5) cyc(1'b0, 1'b0, 1'b1, 16'd16, 1'b1, 16'd6);
    for (int p = 16; p <= 25; p++) px(p, 1'b1, p - 10);
    check_row_valids("valids_stall", 11);

    // Flush at column 5 of row 2; the pixel presented with flush is dropped.
    cyc(1'b1, 1'b1, 1'b1, 16'd26, 1'b1, 16'd16);
    for (int q = 1; q <= 10; q++) px(100 + q, q >= 3, 200 + q);
    check_row_valids("valids_after_flush", 8);

    // Image narrower than the window never yields a window.
    cfg(32'h0, 16'd2, 1'b1);
    for (int p = 1; p <= 6; p++) px(300 + p, 1'b1, 400 + p);
    check_row_valids("valids_narrow", 0);

    // Disabled: pixels are ignored.
    cfg(32'h0, 16'd10, 1'b0);
    px(500, 1'b1, 501);
    px(502, 1'b1, 503);

    // Upper row valid without a live pixel, then flush.
    cfg(32'h0, 16'd10, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, '0, 1'b0, '0);
    cyc(1'b1, 1'b0, 1'b0, '0, 1'b1, 16'd7);
`ifdef LB_WIN_ERR_CHECK_EN
    chk("err_set", WB'(err), WB'(1'b1));
    chk("err_mirror", WB'(read_data[31]), WB'(1'b1));
`else
    chk("err_tied", WB'(err), WB'(1'b0));
`endif
    cyc(1'b1, 1'b0, 1'b0, '0, 1'b0, '0);
    cyc(1'b1, 1'b1, 1'b0, '0, 1'b0, '0);
    chk("err_after_flush", WB'(err), WB'(1'b0));
    chk("rd31_after_flush", WB'(read_data[31]), WB'(1'b0));

    repeat (2) @(posedge clk_in);
    chk("queue_empty_end", WB'(exp_q.size()), WB'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/lb_window_gen.md
Name: lb_window_gen

Overview:
Downstream neighbour of the memory core in line-buffer mode. Consumes the live pixel stream (the same data and write-enable that feed the line buffer) plus the line buffer's delayed-row output (data_out/valid_out). Builds a 2-row x WIN_W-column sliding stencil window and emits it with a single-cycle valid pulse to the PE array. Configured through the standard config bus.

Parameters:
DW, 16, pixel width in bits
WIN_W, 3, window width in columns (2..8)

Ports:
clk_in  input  1  clock
reset  input  1  synchronous active-high reset
clk_en  input  1  global clock enable; 0 freezes all state except config writes
config_en  input  1  config write strobe
config_addr  input  32  config address; only [7:0]==8'h00 decodes, others ignored
config_data  input  32  [15:0] image width W, [16] enable
read_data  output  32  {err, 14'b0, enable, W}
flush  input  1  synchronous stream restart; config preserved
cur_in  input  DW  live pixel (same as line-buffer data_in)
cur_valid  input  1  live pixel valid (same as line-buffer wen_in)
prev_in  input  DW  line-buffer data_out (pixel one row above)
prev_valid  input  1  line-buffer valid_out
win_out  output  2*WIN_W*DW  window; tap k=r*WIN_W+c at [k*DW +: DW], r=0 prev row, r=1 current row, c=0 oldest
win_valid  output  1  window valid pulse
line_end  output  1  pulse: last pixel of a row accepted
err  output  1  protocol error flag (see Optional Feature)

Behaviour:
- Reset (sync, active-high) has priority over everything.
  - Clears W=0, enable=0, all taps, col_cnt, row_cnt, win_out, win_valid, line_end, err, read_data.
  - State -> IDLE.
- Config write: on config_en with addr 0, W and enable load regardless of clk_en. The same write clears col_cnt to 0.
- Advance event A = clk_en & enable & cur_valid & state!=IDLE.
- On A:
  - Both tap rows shift by one column; cur_in and prev_in enter at c=WIN_W-1. prev_in is shifted even when prev_valid=0.
  - col_cnt (16-bit) increments; when col_cnt==W-1 it wraps to 0 and row_cnt (16-bit, saturating at 16'hFFFF) increments.
  - W=0 gives natural wrap at 65536.
- win_valid (registered, latency 1) is set the cycle after an A where state==STREAM, prev_valid=1 and pre-increment col_cnt >= WIN_W-1. Otherwise it is 0.
  - win_out updates only on A and holds between events.
  - Windows never straddle rows; the first WIN_W-1 pixels of each row produce no valid.
  - W < WIN_W: win_valid never asserts.
- line_end (registered, latency 1) is set after an A with pre-increment col_cnt==W-1.
- State machine:
  - IDLE: enable=0. Goes to PRIME when enable=1.
  - PRIME: enabled, line buffer not yet full. Goes to STREAM on the first A with prev_valid=1; that same advance may produce win_valid if col_cnt qualifies.
  - STREAM: steady state.
  - Any state goes to IDLE when enable is written 0.
- Flush (when clk_en=1):
  - Clears taps, col_cnt, row_cnt, win_valid, line_end, err.
  - State -> PRIME if enable=1, else IDLE.
  - A cur_valid in the same cycle is dropped.
- clk_en=0: taps, counters, state and outputs hold. win_valid/line_end stay at their last value and are not re-pulsed.
- Simultaneous config write and A: the write wins for col_cnt (col_cnt becomes 0); taps still shift.

Optional Feature:
LB_WIN_ERR_CHECK_EN
- Defined: err sets (sticky, latency 1) when prev_valid=1 while cur_valid=0 and clk_en=1 and enable=1. It also sets when prev_valid drops to 0 on an A while in STREAM. err is cleared by reset or flush and is mirrored in read_data[31].
- Not defined: err and read_data[31] are tied 0 and no checker logic is built.

Test Plan:
- Reset for 3 cycles -> win_valid=0, line_end=0, err=0, read_data=0, win_out=0.
- Config W=10, enable=1. Stream pixels 1..30 continuously; prev_valid=1 with prev_in=p-10 from pixel 11 on.
  - First win_valid is one cycle after pixel 13, with prev taps 1,2,3 and cur taps 11,12,13.
  - No valid for pixels 21,22; valid again at 23.
  - line_end after pixels 10, 20, 30.
- Same stream with cur_valid random 50% gaps -> identical sequence of win_out values and exactly 8 valids per row from row 1.
- clk_en=0 for 5 cycles mid-row with cur_valid=1 -> no tap, counter or output change; resume continues at the same column.
- flush at col 5 of row 2 -> next 2 accepted pixels produce no valid, col_cnt restarts at 0, and state=PRIME until prev_valid=1.
- With LB_WIN_ERR_CHECK_EN defined: prev_valid=1 while cur_valid=0 -> err=1 next cycle and read_data[31]=1; a following flush clears both.
